// File: rtl/pec_ram_pkg.sv
// Shared constants for the PEC weight/partial-sum RAM access path.
// Default geometry and grant encoding are also used by the RAM wrapper instantiation site.
package pec_ram_pkg;

  localparam int SRAM_DEPTH_BIT_DEF = 6;
  localparam int SRAM_WIDTH_DEF     = 28;

  // Grant encoding: one-hot so each ready is a single bit compare.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_WR   = 2'b01;
  localparam logic [1:0] GNT_RD   = 2'b10;

endpackage

// File: rtl/pec_ram_rsp_fifo.sv
// Read-response buffer: DEPTH-entry synchronous FIFO with push/pop/occupancy.
// Output data comes straight from the storage registers, so it is stable while not popped.
module pec_ram_rsp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 28,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents are qualified by occupancy, so no reset is needed.
  // NOTE: data storage is deliberately not reset -- only control state must be known after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves occupancy unchanged.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign valid    = (occ != '0);

endmodule

// File: rtl/pec_ram_access_ctrl.sv
// Initiator-side controller for the PEC RAM wrapper: serializes independent write and
// read-request channels onto the RAM so read_en and write_en are never both high, and
// returns read data in order through a bounded response buffer.
// Optional feature: define PEC_RAM_RR_ARB_EN for round-robin arbitration on collision;
// otherwise writes have fixed priority.
module pec_ram_access_ctrl
  import pec_ram_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = SRAM_DEPTH_BIT_DEF,
  parameter int SRAM_WIDTH     = SRAM_WIDTH_DEF,
  parameter int RSP_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SRAM_DEPTH_BIT-1:0] wr_addr,
  input  logic [SRAM_WIDTH-1:0]     wr_data,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [SRAM_DEPTH_BIT-1:0] rd_addr,
  output logic                      rd_rsp_valid,
  input  logic                      rd_rsp_ready,
  output logic [SRAM_WIDTH-1:0]     rd_rsp_data,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  output logic                      ram_write_en,
  output logic                      ram_read_en,
  output logic [SRAM_WIDTH-1:0]     ram_data_in,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int CNT_W = OCC_W + 1;

  logic             active;    // low during and until the first edge after reset
  logic             inflight;  // a read was issued last cycle; its data arrives now
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [CNT_W-1:0] pending;
  logic             can_rd;
  logic             rd_ok;
  logic [1:0]       gnt;

  // Holds the readies low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  // Reads in flight plus buffered responses, net of this cycle's pop, must leave room.
  assign pop     = rd_rsp_valid & rd_rsp_ready;
  assign pending = CNT_W'(occ) + CNT_W'(inflight) - CNT_W'(pop);
  assign can_rd  = (pending < CNT_W'(RSP_DEPTH));
  assign rd_ok   = rd_req_valid & can_rd;

`ifdef PEC_RAM_RR_ARB_EN
  logic rr_ptr;  // 0: write wins the next collision, 1: read wins

  // Round-robin pointer flips after every granted collision so neither channel starves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          rr_ptr <= 1'b0;
    else if (active && wr_valid && rd_ok) rr_ptr <= ~rr_ptr;
  end
`endif

  // Grant selection: at most one channel per cycle, only toward a requesting channel.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (active) begin
`ifdef PEC_RAM_RR_ARB_EN
      if (wr_valid && rd_ok) gnt = rr_ptr ? GNT_RD : GNT_WR;
      else if (wr_valid)     gnt = GNT_WR;
      else if (rd_ok)        gnt = GNT_RD;
`else
      if (wr_valid)   gnt = GNT_WR;
      else if (rd_ok) gnt = GNT_RD;
`endif
    end
  end

  assign wr_ready     = (gnt == GNT_WR);
  assign rd_req_ready = (gnt == GNT_RD);

  // RAM-side drive is combinational from the accepted request.
  assign ram_write_en = wr_ready;
  assign ram_addr_w   = wr_addr;
  assign ram_data_in  = wr_data;
  assign ram_read_en  = rd_req_ready;
  assign ram_addr_r   = rd_addr;

  // Marks that RAM read data will be valid on the next cycle; cleared by reset to drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_req_ready;
  end

  pec_ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (SRAM_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_data_out),
    .pop       (pop),
    .pop_data  (rd_rsp_data),
    .valid     (rd_rsp_valid),
    .occ       (occ)
  );

endmodule

// File: tb/tb_pec_ram_access_ctrl.sv
// Directed bench for pec_ram_access_ctrl with a behavioural RAM and a response scoreboard.
// Grant-order expectations follow PEC_RAM_RR_ARB_EN when it is defined.
module tb_pec_ram_access_ctrl;

  localparam int AW = 6;
  localparam int DW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic          ram_write_en, ram_read_en;
  logic [DW-1:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  pec_ram_access_ctrl #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .RSP_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .ram_addr_w   (ram_addr_w),
    .ram_addr_r   (ram_addr_r),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Behavioural single-port RAM: write wins, read data one cycle after read_en.
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_write_en)     ram_mem[ram_addr_w] <= ram_data_in;
    else if (ram_read_en) ram_data_out <= ram_mem[ram_addr_r];
  end

  // Scoreboard state
  logic [DW-1:0] shadow [64];
  logic [DW-1:0] exp_q [$];
  int            rsp_cyc_q [$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            last_wr_fire, last_rd_fire, last_pop;
  int            last_rd_cyc, last_rsp_cyc, rsp_count = 0;
  logic [DW-1:0] last_rsp_data;
  bit            hold_valid = 1'b0;
  logic [DW-1:0] hold_data;
  bit            log_en = 1'b0;
  string         gnt_log;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: observe handshakes mid-cycle, update scoreboard, advance to next negedge.
  task automatic cycle();
    logic [DW-1:0] e;
    #1;
    check("ram_en_exclusive", 32'(ram_write_en & ram_read_en), 32'd0);
    if (hold_valid) begin
      check("rsp_hold_valid", 32'(rd_rsp_valid), 32'd1);
      check("rsp_hold_data", 32'(rd_rsp_data), 32'(hold_data));
    end
    last_wr_fire = wr_valid & wr_ready;
    last_rd_fire = rd_req_valid & rd_req_ready;
    last_pop     = rd_rsp_valid & rd_rsp_ready;
    if (log_en) gnt_log = {gnt_log, last_wr_fire ? "W" : (last_rd_fire ? "R" : "-")};
    if (last_wr_fire) begin
      check("wr_en_drive", 32'(ram_write_en), 32'd1);
      shadow[wr_addr] = wr_data;
    end
    if (last_rd_fire) begin
      check("rd_en_drive", 32'(ram_read_en), 32'd1);
      exp_q.push_back(shadow[rd_addr]);
      last_rd_cyc = cyc;
    end
    if (last_pop) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rd_rsp_data), 32'(e));
      end
      last_rsp_data = rd_rsp_data;
      last_rsp_cyc  = cyc;
      rsp_cyc_q.push_back(cyc);
      rsp_count++;
    end
    hold_valid = rd_rsp_valid & ~rd_rsp_ready;
    hold_data  = rd_rsp_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    last_wr_fire = 1'b0;
    for (int i = 0; i < 20 && !last_wr_fire; i++) cycle();
    check("wr_handshake", 32'(last_wr_fire), 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int    wcnt, rcnt, ridx, base;
    string exp_log;

    // Reset with both channels requesting: nothing may be granted.
    rst_n        = 1'b0;
    wr_valid     = 1'b1;
    wr_addr      = '0;
    wr_data      = '0;
    rd_req_valid = 1'b1;
    rd_addr      = '0;
    rd_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_wr_ready", 32'(wr_ready), 32'd0);
    check("reset_rd_req_ready", 32'(rd_req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("reset_ram_en", 32'({ram_write_en, ram_read_en}), 32'd0);
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);

    // Preload every address, covering the full address range.
    for (int i = 0; i < 64; i++) do_write(AW'(i), DW'(i * 32'h00D5A3 + 32'h0111111));

    // Test 1: write then read, response two cycles after the read handshake.
    do_write(6'h05, 28'hABCDEF0);
    rd_req_valid = 1'b1;
    rd_addr      = 6'h05;
    last_rsp_cyc = -1;
    cycle();
    check("t1_rd_handshake", 32'(last_rd_fire), 32'd1);
    rd_req_valid = 1'b0;
    for (int i = 0; i < 10 && last_rsp_cyc < 0; i++) cycle();
    check("t1_latency", 32'(last_rsp_cyc - last_rd_cyc), 32'd2);
    check("t1_data", 32'(last_rsp_data), 32'h0ABCDEF0);

    // Test 2/3: simultaneous write and read streams; grant order depends on arbitration mode.
    wcnt    = 0;
    rcnt    = 0;
    gnt_log = "";
    log_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_valid     = (wcnt < 4);
      wr_addr      = AW'(16 + wcnt);
      wr_data      = DW'(32'h05A0000 + wcnt);
      rd_req_valid = (rcnt < 4);
      rd_addr      = AW'(16 + rcnt);
      cycle();
      if (last_wr_fire) wcnt++;
      if (last_rd_fire) rcnt++;
    end
    log_en       = 1'b0;
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
`ifdef PEC_RAM_RR_ARB_EN
    exp_log = "WRWRWRWR";
`else
    exp_log = "WWWWRRRR";
`endif
    checks++;
    assert (gnt_log == exp_log) else begin
      errors++;
      $error("FAIL t2_grant_order: got=%s expected=%s", gnt_log, exp_log);
    end
    drain(10);

    // Test 4: backpressure fills the buffer after two reads; writes still flow.
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    ridx         = 0;
    base         = rsp_count;
    for (int k = 0; k < 6; k++) begin
      rd_addr = AW'(ridx);
      cycle();
      if (last_rd_fire) ridx++;
    end
    check("t4_reads_before_full", 32'(ridx), 32'd2);
    rd_addr = AW'(2);
    #1;
    check("t4_rd_req_ready_full", 32'(rd_req_ready), 32'd0);
    do_write(6'h20, 28'h7654321);
    rd_rsp_ready = 1'b1;
    for (int k = 0; k < 10 && ridx < 3; k++) begin
      rd_addr = AW'(ridx);
      cycle();
      if (last_rd_fire) ridx++;
    end
    rd_req_valid = 1'b0;
    drain(10);
    check("t4_rsp_count", 32'(rsp_count - base), 32'd3);

    // Test 5: back-to-back reads at the top and bottom address, one response per cycle.
    rsp_cyc_q.delete();
    rd_req_valid = 1'b1;
    rd_addr      = 6'h3F;
    cycle();
    check("t5_rd_3f", 32'(last_rd_fire), 32'd1);
    rd_addr = 6'h00;
    cycle();
    check("t5_rd_00", 32'(last_rd_fire), 32'd1);
    rd_req_valid = 1'b0;
    drain(10);
    check("t5_rsp_count", 32'(rsp_cyc_q.size()), 32'd2);
    if (rsp_cyc_q.size() == 2) check("t5_rsp_spacing", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd1);

    // Test 6: reset right after a read handshake discards the read.
    rd_req_valid = 1'b1;
    rd_addr      = 6'h07;
    cycle();
    check("t6_rd_handshake", 32'(last_rd_fire), 32'd1);
    rd_req_valid = 1'b0;
    rst_n        = 1'b0;
    exp_q.delete();
    hold_valid = 1'b0;
    base       = rsp_count;
    #1;
    check("t6_reset_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_rsp_after_reset", 32'(rd_rsp_valid), 32'd0);
      cycle();
    end
    check("t6_rsp_count", 32'(rsp_count - base), 32'd0);

    // Controller is usable again after the mid-operation reset.
    rd_req_valid = 1'b1;
    rd_addr      = 6'h07;
    cycle();
    check("t6_post_reset_rd", 32'(last_rd_fire), 32'd1);
    rd_req_valid = 1'b0;
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
